// File: rtl/reg_trace_dump.sv
// Sequential register-file reader: walks the registers through a spare read port and streams
// (index, value) records on a valid/ready port. Define REG_TRACE_DUMP_SKIP_X0_EN to skip x0.
module reg_trace_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rR_o,
  input  logic [31:0]       rD_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [31:0]       dump_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

`ifdef REG_TRACE_DUMP_SKIP_X0_EN
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
`endif
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic              capture;

  // The index register doubles as the read address, so it is cleared whenever the
  // block returns toward IDLE to keep rR_o at zero there.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that leaves one
    // unassigned would infer a latch.
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_next = READ;
          idx_next   = FIRST_IDX;
        end
      end
      READ: begin
        if (abort_i) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          state_next = HOLD;
          capture    = 1'b1;
        end
      end
      HOLD: begin
        if (abort_i) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (dump_ready_i) begin
          if (idx == LAST_IDX) begin
            state_next = DONE;
            idx_next   = '0;
          end else begin
            state_next = READ;
            idx_next   = idx + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Record registers hold the value captured in READ; later register-file writes cannot
  // disturb a record that is waiting for its handshake.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: the record data register is reset because it is a visible output with a
      // defined reset value, unlike a storage array that would only need a valid bit.
      dump_addr_o <= '0;
      dump_data_o <= '0;
    end else if (capture) begin
      dump_addr_o <= idx;
      dump_data_o <= rD_i;
    end
  end

  assign rR_o         = idx;
  assign dump_valid_o = (state == HOLD);
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);

endmodule

// File: tb/tb_reg_trace_dump.sv
// Self-checking bench for reg_trace_dump: directed vector table, stall/abort/reset sequences
// and randomized-ready dumps compared against an expected-record queue.
module tb_reg_trace_dump;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
`ifdef REG_TRACE_DUMP_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NREC = NUM_REGS - FIRST;

  logic              clk = 1'b0;
  logic              reset, start, abort, ready;
  logic [ADDR_W-1:0] rr, daddr;
  logic [31:0]       rd, ddata;
  logic              valid, busy, done;

  logic [31:0] regs [NUM_REGS];

  int n_tests = 0;
  int n_fail  = 0;

  // Register file behaviour: combinational read, x0 hard-wired to zero.
  assign rd = (rr == '0) ? 32'h0 : regs[rr];

  always #5 clk = ~clk;

  reg_trace_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .abort_i     (abort),
    .rR_o        (rr),
    .rD_i        (rd),
    .dump_valid_o(valid),
    .dump_ready_i(ready),
    .dump_addr_o (daddr),
    .dump_data_o (ddata),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] preload_val(input int k);
    return (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);
  endfunction

  task automatic preload();
    for (int k = 0; k < NUM_REGS; k++) regs[k] = preload_val(k);
  endtask

  task automatic run_to_hold(input int target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (valid && 32'(daddr) == 32'(target)) found = 1'b1;
      else begin
        ready = 1'b1;
        step();
      end
    end
  endtask

  // One complete dump. The expected records come from a snapshot of the register file
  // taken at start; ready is random with the given percentage, optionally forced low for
  // five cycles on one record (with that register rewritten meanwhile), and start can be
  // re-pulsed mid-dump.
  task automatic run_dump(input int ready_pct, input int stall_rec, input int restart_at);
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    int  exp_idx, n, last_hs, done_cnt, done_edge, idle_edge, stall_left;
    bit  fin, prev_stall, ready_now;
    for (int k = FIRST; k < NUM_REGS; k++) exp_q.push_back((k == 0) ? 32'h0 : regs[k]);
    exp_idx = 0; last_hs = -1; done_cnt = 0; done_edge = -1; idle_edge = -1;
    stall_left = 5; fin = 1'b0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    start = 1'b1; ready = 1'b0;
    step();
    start = 1'b0;
    n = 0;
    check("dump_busy_after_start", 32'(busy), 1);
    check("dump_rr_first", 32'(rr), 32'(FIRST));
    while (!fin && n < 400) begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(valid), 1);
        check("stall_addr_held", 32'(daddr), 32'(prev_addr));
        check("stall_data_held", ddata, prev_data);
      end
      if (done) begin
        done_cnt++;
        done_edge = n;
      end
      if (done_edge >= 0 && !busy) begin
        fin = 1'b1;
        idle_edge = n;
      end
      if (valid && stall_rec >= 0 && 32'(daddr) == 32'(stall_rec) && stall_left > 0) begin
        ready_now = 1'b0;
        stall_left--;
        regs[stall_rec] = 32'hDEAD_BEEF;
      end else begin
        ready_now = ($urandom_range(99) < 32'(ready_pct));
      end
      ready = ready_now;
      start = (n == restart_at);
      if (valid && ready_now) begin
        check("rec_addr", 32'(daddr), 32'(FIRST + exp_idx));
        if (exp_idx < NREC) check("rec_data", ddata, exp_q[exp_idx]);
        else check("extra_record", 32'(exp_idx), 32'(NREC - 1));
        exp_idx++;
        last_hs = n + 1;
      end
      prev_stall = valid && !ready_now;
      prev_addr  = daddr;
      prev_data  = ddata;
      if (!fin) begin
        step();
        n++;
      end
    end
    ready = 1'b0;
    start = 1'b0;
    check("dump_finished", 32'(fin), 1);
    check("dump_records", 32'(exp_idx), 32'(NREC));
    check("done_pulses", 32'(done_cnt), 1);
    check("done_after_last_hs", 32'(done_edge), 32'(last_hs));
    check("busy_low_after_done", 32'(idle_edge), 32'(done_edge + 1));
    if (ready_pct == 100 && stall_rec < 0) check("last_hs_edge", 32'(last_hs), 32'(2 * NREC));
    check("idle_valid", 32'(valid), 0);
    check("idle_rr", 32'(rr), 0);
  endtask

  typedef struct {
    logic start;
    logic abort;
    logic ready;
    logic valid;
    logic busy;
    logic done;
    int   rr;
    int   addr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    bit found;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FIRST,     0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FIRST,     FIRST};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FIRST,     FIRST};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, FIRST + 1, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, FIRST + 1, FIRST + 1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,         0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,         0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,         0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FIRST,     0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,         0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,         0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    preload();
    @(negedge clk);
    @(negedge clk);
    check("reset_valid", 32'(valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_rr", 32'(rr), 0);
    check("reset_addr", 32'(daddr), 0);
    check("reset_data", ddata, 32'h0);
    reset = 1'b0;
    step();

    // Directed vectors: stall, start during a dump, abort over handshake, abort+start in IDLE.
    for (int i = 0; i < 11; i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      ready = vecs[i].ready;
      step();
      start = 1'b0;
      abort = 1'b0;
      ready = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("vec%0d_rr", i), 32'(rr), 32'(vecs[i].rr));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d_addr", i), 32'(daddr), 32'(vecs[i].addr));
        check($sformatf("vec%0d_data", i), ddata, preload_val(vecs[i].addr));
      end
    end

    // Full dump with ready high, then a record-7 stall with reg 7 rewritten, then a re-pulsed start.
    run_dump(100, -1, -1);
    preload();
    run_dump(100, 7, -1);
    preload();
    run_dump(100, -1, 10);

    // Abort while record 12 is held, with ready high in the same cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_hold(12, found);
    check("abort_reached_rec12", 32'(found), 1);
    abort = 1'b1;
    ready = 1'b1;
    step();
    abort = 1'b0;
    ready = 1'b0;
    check("abort_valid", 32'(valid), 0);
    check("abort_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", 32'(done), 0);
      step();
    end
    run_dump(100, -1, -1);

    // Asynchronous reset in the middle of a cycle while record 20 is held.
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_hold(20, found);
    check("reset_reached_rec20", 32'(found), 1);
    ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midreset_valid", 32'(valid), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_done", 32'(done), 0);
    check("midreset_rr", 32'(rr), 0);
    check("midreset_addr", 32'(daddr), 0);
    check("midreset_data", ddata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_reset_idle_valid", 32'(valid), 0);
      check("post_reset_idle_busy", 32'(busy), 0);
      check("post_reset_idle_done", 32'(done), 0);
    end

    // Randomized register contents and ready patterns.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] = $urandom;
      run_dump(30 + r * 20, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
